// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU (fixed priority, byte/half/word with alignment) vs debug word port.
// A starvation counter lets the debug port win once after STARVE_LIMIT consecutive denials.
module dmem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              misaligned
);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic       vld;
    logic       dbg;
    logic [1:0] size;
    logic [1:0] off;
    logic       uns;
    logic       mis;
  } rsp_t;

  logic [SC_W-1:0] starve_cnt;
  rsp_t            rsp;
  logic            mis_q;
  logic            dbg_win, mis;
  logic [1:0]      off;
  logic [3:0]      cpu_mask;
  logic [31:0]     cpu_wd, shifted, ld_ext;
  logic            unused_addr;

  assign off         = cpu_addr[1:0];
  assign unused_addr = ^cpu_addr[31:ADDR_W+2];

  // Lane mask / replicated data; size 3 falls into the word branch.
  always_comb begin
    cpu_mask = 4'b0000;
    cpu_wd   = cpu_wdata;
    mis      = 1'b0;
    case (cpu_size)
      2'd0: begin
        cpu_mask = 4'b0001 << off;
        cpu_wd   = {4{cpu_wdata[7:0]}};
      end
      2'd1: begin
        cpu_wd = (off == 2'd1) ? {8'h00, cpu_wdata[15:0], 8'h00} : {2{cpu_wdata[15:0]}};
        case (off)
          2'd0:    cpu_mask = 4'b0011;
          2'd1:    cpu_mask = 4'b0110;
          2'd2:    cpu_mask = 4'b1100;
          default: mis      = 1'b1;
        endcase
      end
      default: begin
        mis      = (off != 2'd0);
        cpu_mask = mis ? 4'b0000 : 4'b1111;
      end
    endcase
  end

  assign dbg_win = dbg_req && (starve_cnt == SC_W'(STARVE_LIMIT));
  assign cpu_gnt = !rst && cpu_req && !dbg_win;
  assign dbg_gnt = !rst && dbg_req && !cpu_gnt;

  always_comb begin
    mem_en    = cpu_gnt || dbg_gnt;
    mem_addr  = dbg_gnt ? dbg_addr : cpu_addr[ADDR_W+1:2];
    mem_wdata = dbg_gnt ? dbg_wdata : cpu_wd;
    mem_we    = 4'b0000;
    if (cpu_gnt && cpu_we)      mem_we = cpu_mask;
    else if (dbg_gnt && dbg_we) mem_we = 4'b1111;
  end

  always_ff @(posedge clk) begin
    if (rst || !dbg_req || dbg_gnt)            starve_cnt <= '0;
    else if (starve_cnt != SC_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp   <= '0;
      mis_q <= 1'b0;
    end else begin
      rsp.vld  <= (cpu_gnt && !cpu_we) || (dbg_gnt && !dbg_we);
      rsp.dbg  <= dbg_gnt;
      rsp.size <= cpu_size;
      rsp.off  <= off;
      rsp.uns  <= cpu_unsigned;
      rsp.mis  <= mis;
      mis_q    <= cpu_gnt && mis;
    end
  end

  // Gating with rst drops a response whose load was granted just before reset.
  always_comb begin
    shifted = mem_rdata >> {rsp.off, 3'b000};
    case (rsp.size)
      2'd0:    ld_ext = rsp.uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    ld_ext = rsp.uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
    cpu_rvalid = rsp.vld && !rsp.dbg && !rst;
    dbg_rvalid = rsp.vld && rsp.dbg && !rst;
    cpu_rdata  = (cpu_rvalid && !rsp.mis) ? ld_ext : 32'h0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : 32'h0;
    misaligned = mis_q && !rst;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Random + directed bench for dmem_arbiter against a byte-addressed memory model.
module tb_dmem_arbiter;
  localparam int AW    = 14;
  localparam int LIMIT = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req = 0, cpu_we = 0, cpu_unsigned = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic [1:0] cpu_size = 0;
  logic cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, misaligned;
  logic [31:0] cpu_rdata, dbg_rdata, mem_wdata;
  logic dbg_req = 0, dbg_we = 0;
  logic [AW-1:0] dbg_addr = 0, mem_addr;
  logic [31:0] dbg_wdata = 0;
  logic [3:0] mem_we;
  logic [31:0] mem_rdata = 0;

  dmem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
    .cpu_unsigned(cpu_unsigned), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Physical memory macro with registered read.
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) ram[mem_addr[7:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  // Reference model: byte-addressed memory plus arbitration rules.
  logic [7:0] mb [0:1023];
  int sc = 0;
  logic p_cv = 0, p_dv = 0, p_mis = 0;
  logic [31:0] p_cd = 0, p_dd = 0;
  logic [31:0] obs_crd, obs_drd;
  logic obs_mis, obs_crv, obs_dg;
  logic [3:0] obs_we;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mword(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction

  task automatic step();
    logic cg, dg, mis;
    int n, ba;
    logic [1:0] off;
    logic [3:0] we_e;
    longint v;
    #1;
    if (rst) begin p_cv = 0; p_cd = 0; p_dv = 0; p_dd = 0; p_mis = 0; end
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(p_cv));
    chk("cpu_rdata",  cpu_rdata, p_cd);
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(p_dv));
    chk("dbg_rdata",  dbg_rdata, p_dd);
    chk("misaligned", 32'(misaligned), 32'(p_mis));
    obs_crd = cpu_rdata; obs_drd = dbg_rdata; obs_mis = misaligned; obs_crv = cpu_rvalid;

    cg = !rst && cpu_req && !(dbg_req && sc == LIMIT);
    dg = !rst && dbg_req && !cg;
    chk("cpu_gnt", 32'(cpu_gnt), 32'(cg));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(dg));
    chk("mem_en",  32'(mem_en), 32'(cg || dg));
    obs_dg = dbg_gnt; obs_we = mem_we;

    n   = (cpu_size == 2'd0) ? 1 : (cpu_size == 2'd1) ? 2 : 4;
    off = cpu_addr[1:0];
    mis = (n == 2 && off == 2'd3) || (n == 4 && off != 2'd0);
    ba  = int'(cpu_addr[9:0]);
    we_e = 4'b0000;
    if (cg && cpu_we && !mis) we_e = 4'(((1 << n) - 1) << off);
    else if (dg && dbg_we)    we_e = 4'b1111;
    chk("mem_we", 32'(mem_we), 32'(we_e));
    if (cg)      chk("mem_addr", 32'(mem_addr), 32'(cpu_addr[AW+1:2]));
    else if (dg) chk("mem_addr", 32'(mem_addr), 32'(dbg_addr));

    p_cv = cg && !cpu_we;
    p_cd = 0;
    if (p_cv && !mis) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(mb[ba+i]) << (8*i));
      if (!cpu_unsigned && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 1);
      p_cd = v[31:0];
    end
    p_dv  = dg && !dbg_we;
    p_dd  = p_dv ? mword(int'(dbg_addr[7:0])) : 32'h0;
    p_mis = cg && mis;

    if (cg && cpu_we && !mis)
      for (int i = 0; i < n; i++) mb[ba+i] = cpu_wdata[8*i +: 8];
    if (dg && dbg_we)
      for (int i = 0; i < 4; i++) mb[4*int'(dbg_addr[7:0])+i] = dbg_wdata[8*i +: 8];

    if (rst || !dbg_req || dg) sc = 0;
    else if (sc < LIMIT)       sc++;
    @(negedge clk);
  endtask

  task automatic idle();
    cpu_req = 0; dbg_req = 0;
    step();
  endtask

  task automatic set_cpu(input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] d);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_size = sz; cpu_unsigned = u; cpu_wdata = d;
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [1:0] sz,
                    input logic u, input logic [31:0] e, input logic em);
    set_cpu(1'b0, a, sz, u, 32'h0); dbg_req = 0;
    step(); idle();
    chk(tag, obs_crd, e);
    chk({tag, "_mis"}, 32'(obs_mis), 32'(em));
  endtask

  task automatic st(input string tag, input logic [31:0] a, input logic [1:0] sz,
                    input logic [31:0] d, input logic [3:0] ew);
    set_cpu(1'b1, a, sz, 1'b0, d); dbg_req = 0;
    step();
    chk(tag, 32'(obs_we), 32'(ew));
    idle();
  endtask

  task automatic dwr(input int w, input logic [31:0] d);
    cpu_req = 0; dbg_req = 1; dbg_we = 1; dbg_addr = AW'(w); dbg_wdata = d;
    step(); idle();
  endtask

  task automatic drd(input string tag, input int w, input logic [31:0] e);
    cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = AW'(w);
    step(); idle();
    chk(tag, obs_drd, e);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    for (int i = 0; i < 1024; i++) mb[i] = 8'h0;
    @(negedge clk);
    cpu_req = 1; dbg_req = 1;
    step(); step();
    rst = 0; idle();

    // Alignment / extension
    dwr(0, 32'h80FF_7F01);
    ld("lb0", 0, 2'd0, 0, 32'h0000_0001, 0);
    ld("lb1", 1, 2'd0, 0, 32'h0000_007F, 0);
    ld("lb2", 2, 2'd0, 0, 32'hFFFF_FFFF, 0);
    ld("lb3", 3, 2'd0, 0, 32'hFFFF_FF80, 0);
    ld("lbu3", 3, 2'd0, 1, 32'h0000_0080, 0);
    ld("lh0", 0, 2'd1, 0, 32'h0000_7F01, 0);
    ld("lh1", 1, 2'd1, 0, 32'hFFFF_FF7F, 0);
    ld("lh2", 2, 2'd1, 0, 32'hFFFF_80FF, 0);
    ld("lh3", 3, 2'd1, 0, 32'h0000_0000, 1);
    ld("lw1", 1, 2'd2, 0, 32'h0000_0000, 1);

    // Stores
    for (int w = 6; w <= 9; w++) dwr(w, 32'h0);
    st("sb_we0", 24, 2'd0, 32'hAABB_CCDD, 4'b0001);
    st("sb_we1", 29, 2'd0, 32'hAABB_CCDD, 4'b0010);
    st("sb_we2", 34, 2'd0, 32'hAABB_CCDD, 4'b0100);
    st("sb_we3", 39, 2'd0, 32'hAABB_CCDD, 4'b1000);
    drd("sb6", 6, 32'h0000_00DD);
    drd("sb7", 7, 32'h0000_DD00);
    drd("sb8", 8, 32'h00DD_0000);
    drd("sb9", 9, 32'hDD00_0000);
    dwr(4, 32'h1234_5678);
    st("sh3_we", 19, 2'd1, 32'h1122_3344, 4'b0000);
    drd("sh3_mem", 4, 32'h1234_5678);
    st("sh1_we", 17, 2'd1, 32'h1122_3344, 4'b0110);
    drd("sh1_mem", 4, 32'h1233_4478);

    // Contention: debug wins every ninth cycle
    set_cpu(1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
    dbg_req = 1; dbg_we = 0; dbg_addr = AW'(6);
    for (int c = 1; c <= 27; c++) begin
      step();
      chk("arb_dbg", 32'(obs_dg), 32'(c % 9 == 0));
    end
    idle();

    // Alternating CPU load / debug read on consecutive cycles
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) begin
        set_cpu(1'b0, 32'($urandom_range(0, 39)), 2'($urandom_range(0, 2)), 1'($urandom), 32'h0);
        dbg_req = 0;
      end else begin
        cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = AW'($urandom_range(0, 9));
      end
      step();
    end
    idle();

    // Reset right after a granted load
    set_cpu(1'b0, 32'h0, 2'd2, 1'b0, 32'h0); dbg_req = 0;
    step();
    rst = 1; dbg_req = 1;
    step();
    chk("rst_drop", 32'(obs_crv), 32'h0);
    rst = 0; idle();
    chk("rst_after", obs_crd, 32'h0);

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      rst          = ($urandom_range(0, 59) == 0);
      cpu_req      = 1'($urandom);
      cpu_we       = 1'($urandom);
      cpu_addr     = 32'($urandom_range(0, 127));
      cpu_size     = 2'($urandom);
      cpu_unsigned = 1'($urandom);
      cpu_wdata    = $urandom;
      dbg_req      = ($urandom_range(0, 3) != 0);
      dbg_we       = 1'($urandom);
      dbg_addr     = AW'($urandom_range(0, 31));
      dbg_wdata    = $urandom;
      step();
    end
    rst = 0; idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
